instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Writer side of the instruction path: accepts field-level instruction requests over a valid/ready handshake.
//  Encodes each request into a 32-bit MIPS word (R/I/J formats), buffers it in a small FIFO and writes it
//  sequentially into instruction memory. Used by benches and the boot loader to load programs that the
//  control/aluControl/ALU datapath later decodes and executes.
// PARAMETERS
//  FIFO_DEPTH  4  encoded-word buffer entries (power of 2, >=2)
//  ADDR_WIDTH  8  instruction-memory word-address width
//  BASE_ADDR   0  first word address written after reset/restart
// PORTS
//  clk              in   1   single clock, rising edge
//  resetN           in   1   asynchronous active-low reset
//  reqValid         in   1   request present
//  reqReady         out  1   block accepts request this cycle
//  reqClass         in   2   00=R, 01=I, 10=J, 11=illegal
//  reqOpcode        in   6   opcode (ignored for R; R forces 6'b000000)
//  reqRs/reqRt/reqRd in  5   register fields
//  reqShamt         in   5   shift amount (R only)
//  reqFunct         in   6   function field (R only)
//  reqImm           in   16  immediate (I only)
//  reqTarget        in   26  jump target (J only)
//  finish           in   1   pulse: no more requests, drain and stop
//  restart          in   1   pulse in DONE/OVERFLOW: return to LOAD at BASE_ADDR
//  memStall         in   1   instruction memory cannot take a write this cycle
//  memWriteEnable   out  1   write strobe
//  memWriteAddress  out  AW  word address
//  memWriteData     out  32  encoded instruction
//  loadDone         out  1   high in DONE
//  addrOverflow     out  1   sticky: address space exhausted
//  encodeError      out  1   sticky: illegal reqClass seen
//  fifoCount        out  log2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (async, resetN=0): state=LOAD, FIFO empty, address=BASE_ADDR; all outputs 0 except reqReady=1.
//  Encode: R={6'b0,rs,rt,rd,shamt,funct}; I={opcode,rs,rt,imm}; J={opcode,target}. Combinational; the result
//   is pushed into the FIFO on the accepting edge.
//  Accept: reqValid&reqReady. reqReady = (state==LOAD) & FIFO not full; no dependence on reqValid.
//  Illegal class: request accepted (handshake completes), nothing pushed, encodeError set (sticky until reset/restart).
//  Write stage: output register. When FIFO non-empty and (!memWriteEnable | !memStall), pop into the register;
//   memWriteEnable=1, address=current pointer. While memStall=1 and memWriteEnable=1, hold address/data/enable.
//   Pointer increments on each completed write (memWriteEnable&!memStall).
//  Latency: accept at edge E, empty FIFO, no stall -> memWriteEnable=1 in the cycle after E+1 (2 cycles).
//   Throughput: 1 word/cycle sustained.
//  Simultaneous push and pop while full: allowed only when reqReady was high at that cycle; FIFO never overflows.
//  FSM: LOAD -(finish)-> DRAIN; DRAIN -(FIFO empty & no pending write)-> DONE; DONE/OVERFLOW -(restart)-> LOAD.
//   finish with accepted request in the same cycle: request kept, then DRAIN. finish outside LOAD is ignored.
//  Overflow: completed write at address 2^AW-1 -> OVERFLOW: addrOverflow=1, reqReady=0, FIFO flushed,
//   no further writes; the pointer never wraps.
//  restart: flushes FIFO, clears stickies, address=BASE_ADDR, enters LOAD next cycle.
//  Reset mid-operation: everything is abandoned; partially written program is not cleaned up.
// STRUCTURE
//  Package mips_isa_pkg: opcode/funct constants, reqClass encodings (CLASS_R/I/J), field bit positions,
//   encoder state enum.
//  Sub-module sync_fifo #(WIDTH=32, DEPTH) with push/pop/full/empty/count; encoder, FSM, write stage in top.
// TESTING
//  R add $3,$1,$2 (rs=1,rt=2,rd=3,funct=0x20) -> memWriteData=0x00221820 at addr 0, 2 cycles after accept.
//  I lw $8,4($29) (op=0x23,rs=29,rt=8,imm=4) then J op=2 target=0x10 -> 0x8FA80004 @0, 0x08000010 @1, back-to-back.
//  memStall=1 for 8 cycles, 6 requests -> reqReady drops after 5 accepts (4 FIFO + 1 output reg); no loss, order kept.
//  reqClass=11 between two valid requests -> encodeError=1, addresses 0,1 hold the two valid words only.
//  ADDR_WIDTH=2, 6 requests -> writes @0..3, addrOverflow=1, reqReady=0; restart -> next write @0, flags clear.
//  finish after 3 requests -> DRAIN, loadDone=1 once 3 writes complete; resetN low mid-DRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS instruction-format definitions for the instruction loader.
// Holds the request class codes, field bit positions, common opcodes and the loader state type.
package mips_isa_pkg;

  localparam logic [1:0] CLASS_R = 2'b00;
  localparam logic [1:0] CLASS_I = 2'b01;
  localparam logic [1:0] CLASS_J = 2'b10;
  localparam logic [1:0] CLASS_X = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_OVERFLOW
  } enc_state_t;

  // R-type always carries the all-zero opcode regardless of what the requester supplied.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  cls,
    input logic [5:0]  opcode,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    word = '0;
    unique case (cls)
      CLASS_R: begin
        word[OPCODE_LSB +: 6] = OP_RTYPE;
        word[RS_LSB     +: 5] = rs;
        word[RT_LSB     +: 5] = rt;
        word[RD_LSB     +: 5] = rd;
        word[SHAMT_LSB  +: 5] = shamt;
        word[FUNCT_LSB  +: 6] = funct;
      end
      CLASS_I: begin
        word[OPCODE_LSB +: 6]  = opcode;
        word[RS_LSB     +: 5]  = rs;
        word[RT_LSB     +: 5]  = rt;
        word[IMM_LSB    +: 16] = imm;
      end
      CLASS_J: begin
        word[OPCODE_LSB +: 6]  = opcode;
        word[TARGET_LSB +: 26] = target;
      end
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data at the head entry.
// A push into a full FIFO is taken only when a pop happens on the same edge; flush wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & (!full | pop);
  assign pop_ok  = pop & !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes field-level instruction requests into MIPS words, buffers them and writes them
// sequentially into instruction memory through a stall-tolerant output register.
module instruction_encoder
  import mips_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         reqValid,
  output logic                         reqReady,
  input  logic [1:0]                   reqClass,
  input  logic [5:0]                   reqOpcode,
  input  logic [4:0]                   reqRs,
  input  logic [4:0]                   reqRt,
  input  logic [4:0]                   reqRd,
  input  logic [4:0]                   reqShamt,
  input  logic [5:0]                   reqFunct,
  input  logic [15:0]                  reqImm,
  input  logic [25:0]                  reqTarget,
  input  logic                         finish,
  input  logic                         restart,
  input  logic                         memStall,
  output logic                         memWriteEnable,
  output logic [ADDR_WIDTH-1:0]        memWriteAddress,
  output logic [31:0]                  memWriteData,
  output logic                         loadDone,
  output logic                         addrOverflow,
  output logic                         encodeError,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCount
);

  localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

  enc_state_t state_q;
  enc_state_t state_d;

  logic [31:0]           word_p0;
  logic                  accept;
  logic                  legal;
  logic                  push;
  logic                  pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [31:0]           fifo_dout;
  logic                  vld_p1;
  logic [31:0]           data_p1;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  write_done;
  logic                  ovf_hit;
  logic                  restart_hit;
  logic                  active;
  logic                  err_q;

  // Stage p0: combinational encode of the request currently on the bus
  assign word_p0 = encode_word(reqClass, reqOpcode, reqRs, reqRt, reqRd,
                               reqShamt, reqFunct, reqImm, reqTarget);

  assign reqReady    = (state_q == ST_LOAD) & !fifo_full;
  assign accept      = reqValid & reqReady;
  assign legal       = (reqClass != CLASS_X);
  assign push        = accept & legal;
  assign active      = (state_q == ST_LOAD) | (state_q == ST_DRAIN);
  assign restart_hit = restart & ((state_q == ST_DONE) | (state_q == ST_OVERFLOW));
  assign write_done  = vld_p1 & !memStall;
  // The last address ends the load: nothing further may be popped, so the pointer never wraps.
  assign ovf_hit     = write_done & (ptr_q == LAST_PTR);
  assign pop         = !fifo_empty & (!vld_p1 | !memStall) & active & !ovf_hit;
  assign fifo_flush  = restart_hit | ovf_hit;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .flush  (fifo_flush),
    .push   (push),
    .pop    (pop),
    .din    (word_p0),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifoCount)
  );

  // Stage p1: memory write register, held while the memory stalls
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ptr_q   <= BASE_PTR;
    end else if (restart_hit) begin
      vld_p1  <= 1'b0;
      ptr_q   <= BASE_PTR;
    end else if (ovf_hit) begin
      vld_p1  <= 1'b0;
    end else begin
      if (write_done) ptr_q <= ptr_q + ADDR_WIDTH'(1);
      if (pop) begin
        vld_p1  <= 1'b1;
        data_p1 <= fifo_dout;
      end else if (write_done) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                  err_q <= 1'b0;
    else if (restart_hit)         err_q <= 1'b0;
    else if (accept && !legal)    err_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: begin
        if (ovf_hit)     state_d = ST_OVERFLOW;
        else if (finish) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ovf_hit)                                  state_d = ST_OVERFLOW;
        else if (fifo_empty && (!vld_p1 || write_done)) state_d = ST_DONE;
      end
      ST_DONE, ST_OVERFLOW: begin
        if (restart) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign memWriteEnable  = vld_p1;
  assign memWriteAddress = ptr_q;
  assign memWriteData    = data_p1;
  assign loadDone        = (state_q == ST_DONE);
  assign addrOverflow    = (state_q == ST_OVERFLOW);
  assign encodeError     = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a default-size instance plus a 2-bit-address instance
// sharing the same request stimulus, with completed memory writes logged per instance.
module tb_instruction_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN, reqValid, finish, restart, memStall;
  logic [1:0]  reqClass;
  logic [5:0]  reqOpcode, reqFunct;
  logic [4:0]  reqRs, reqRt, reqRd, reqShamt;
  logic [15:0] reqImm;
  logic [25:0] reqTarget;

  logic        a_ready, a_we, a_done, a_ovf, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_data;
  logic [2:0]  a_count;
  logic        b_ready, b_we, b_done, b_ovf, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_count;

  instruction_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(a_ready),
    .reqClass(reqClass), .reqOpcode(reqOpcode), .reqRs(reqRs), .reqRt(reqRt),
    .reqRd(reqRd), .reqShamt(reqShamt), .reqFunct(reqFunct), .reqImm(reqImm),
    .reqTarget(reqTarget), .finish(finish), .restart(restart), .memStall(memStall),
    .memWriteEnable(a_we), .memWriteAddress(a_addr), .memWriteData(a_data),
    .loadDone(a_done), .addrOverflow(a_ovf), .encodeError(a_err), .fifoCount(a_count)
  );

  instruction_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(b_ready),
    .reqClass(reqClass), .reqOpcode(reqOpcode), .reqRs(reqRs), .reqRt(reqRt),
    .reqRd(reqRd), .reqShamt(reqShamt), .reqFunct(reqFunct), .reqImm(reqImm),
    .reqTarget(reqTarget), .finish(finish), .restart(restart), .memStall(memStall),
    .memWriteEnable(b_we), .memWriteAddress(b_addr), .memWriteData(b_data),
    .loadDone(b_done), .addrOverflow(b_ovf), .encodeError(b_err), .fifoCount(b_count)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  a_la[$];
  logic [31:0] a_ld[$];
  int unsigned a_lc[$];
  logic [1:0]  b_la[$];
  logic [31:0] b_ld[$];

  always @(negedge clk) begin
    if (a_we && !memStall) begin
      a_la.push_back(a_addr);
      a_ld.push_back(a_data);
      a_lc.push_back(cyc);
    end
    if (b_we && !memStall) begin
      b_la.push_back(b_addr);
      b_ld.push_back(b_data);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    a_la.delete(); a_ld.delete(); a_lc.delete();
    b_la.delete(); b_ld.delete();
  endtask

  task automatic clear_inputs();
    reqValid = 0; finish = 0; restart = 0; memStall = 0;
    reqClass = 0; reqOpcode = 0; reqRs = 0; reqRt = 0; reqRd = 0;
    reqShamt = 0; reqFunct = 0; reqImm = 0; reqTarget = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 0;
    step();
    step();
    clear_logs();
    resetN = 1;
    step();
  endtask

  // addi $0,$0,imm -> 0x20000000 | imm
  task automatic set_i(input logic [15:0] imm);
    reqClass = 2'b01; reqOpcode = 6'h08; reqRs = 0; reqRt = 0; reqImm = imm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic acc;
    clear_inputs();
    resetN = 1;
    #2 resetN = 0;
    #2;
    check("rst_ready", a_ready, 1);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 0);
    check("rst_data", a_data, 0);
    check("rst_done", a_done, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_err", a_err, 0);
    check("rst_count", a_count, 0);
    step();
    resetN = 1;
    step();

    // R add $3,$1,$2 with a junk opcode that must be ignored
    do_reset();
    reqClass = 2'b00; reqOpcode = 6'h3F; reqRs = 1; reqRt = 2; reqRd = 3;
    reqShamt = 0; reqFunct = 6'h20; reqValid = 1;
    check("r_ready", a_ready, 1);
    step();
    reqValid = 0;
    check("r_lat1_we", a_we, 0);
    check("r_lat1_count", a_count, 1);
    step();
    check("r_lat2_we", a_we, 1);
    check("r_addr", a_addr, 0);
    check("r_data", a_data, 32'h00221820);

    // lw then j, back to back
    do_reset();
    reqClass = 2'b01; reqOpcode = 6'h23; reqRs = 29; reqRt = 8; reqImm = 16'h0004; reqValid = 1;
    step();
    reqClass = 2'b10; reqOpcode = 6'h02; reqTarget = 26'h10;
    step();
    reqValid = 0;
    repeat (4) step();
    check("ij_n", a_ld.size(), 2);
    check("ij_d0", a_ld[0], 32'h8FA80004);
    check("ij_a0", a_la[0], 0);
    check("ij_d1", a_ld[1], 32'h08000010);
    check("ij_a1", a_la[1], 1);
    check("ij_b2b", a_lc[1] - a_lc[0], 1);

    // stalled memory: five accepts fill FIFO + output register
    do_reset();
    memStall = 1;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      set_i(16'h0100 + 16'(idx));
      reqValid = 1;
      acc = a_ready;
      step();
      if (acc) idx++;
    end
    check("st_accepts", idx, 5);
    check("st_ready", a_ready, 0);
    check("st_count", a_count, 4);
    check("st_we", a_we, 1);
    check("st_nowrite", a_ld.size(), 0);
    memStall = 0;
    for (int k = 0; k < 20 && idx < 6; k++) begin
      set_i(16'h0100 + 16'(idx));
      acc = a_ready;
      step();
      if (acc) idx++;
    end
    reqValid = 0;
    repeat (8) step();
    check("st_n", a_ld.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("st_d%0d", i), a_ld[i], 32'h20000100 + i);
      check($sformatf("st_a%0d", i), a_la[i], i);
    end

    // illegal class between two valid requests
    do_reset();
    set_i(16'h0011); reqValid = 1;
    step();
    reqClass = 2'b11;
    step();
    set_i(16'h0022);
    step();
    reqValid = 0;
    repeat (4) step();
    check("il_err", a_err, 1);
    check("il_n", a_ld.size(), 2);
    check("il_d0", a_ld[0], 32'h20000011);
    check("il_a0", a_la[0], 0);
    check("il_d1", a_ld[1], 32'h20000022);
    check("il_a1", a_la[1], 1);

    // overflow of the 2-bit address instance, then restart
    do_reset();
    reqClass = 2'b11; reqValid = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      set_i(16'h0040 + 16'(i));
      step();
    end
    reqValid = 0;
    repeat (4) step();
    check("ov_n", b_ld.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ov_d%0d", i), b_ld[i], 32'h20000040 + i);
      check($sformatf("ov_a%0d", i), b_la[i], i);
    end
    check("ov_flag", b_ovf, 1);
    check("ov_ready", b_ready, 0);
    check("ov_count", b_count, 0);
    check("ov_we", b_we, 0);
    check("ov_err", b_err, 1);
    restart = 1;
    step();
    restart = 0;
    check("rs_ovf", b_ovf, 0);
    check("rs_err", b_err, 0);
    check("rs_ready", b_ready, 1);
    check("rs_done", b_done, 0);
    clear_logs();
    set_i(16'h0055); reqValid = 1;
    step();
    reqValid = 0;
    repeat (3) step();
    check("rs_n", b_ld.size(), 1);
    check("rs_a0", b_la[0], 0);
    check("rs_d0", b_ld[0], 32'h20000055);

    // finish with the third request, then drain to DONE
    do_reset();
    set_i(16'h0031); reqValid = 1;
    step();
    set_i(16'h0032);
    step();
    set_i(16'h0033); finish = 1;
    step();
    finish = 0; reqValid = 0;
    check("fin_ready", a_ready, 0);
    for (int k = 0; k < 20 && !a_done; k++) step();
    check("fin_done", a_done, 1);
    check("fin_n", a_ld.size(), 3);
    check("fin_d2", a_ld[2], 32'h20000033);
    check("fin_a2", a_la[2], 2);

    // asynchronous reset while draining
    do_reset();
    memStall = 1;
    set_i(16'h0061); reqValid = 1;
    step();
    set_i(16'h0062); finish = 1;
    step();
    finish = 0; reqValid = 0;
    step();
    check("md_we", a_we, 1);
    check("md_ready", a_ready, 0);
    check("md_count", a_count, 1);
    #2 resetN = 0;
    #1;
    check("ar_we", a_we, 0);
    check("ar_addr", a_addr, 0);
    check("ar_data", a_data, 0);
    check("ar_done", a_done, 0);
    check("ar_ovf", a_ovf, 0);
    check("ar_err", a_err, 0);
    check("ar_count", a_count, 0);
    check("ar_ready", a_ready, 1);
    memStall = 0;
    step();
    resetN = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
